// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// slave is the buffer side, master is the fetch/decode/control side.
interface if_id_buf_if;
   logic        if_valid_i;
   logic        if_ready_o;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        flush_i;
   logic [31:0] stall_cnt_o;

   modport slave (
      input  if_valid_i, pc_i, inst_i,
      input  id_ready_i, flush_i,
      output if_ready_o, id_valid_o,
      output pc_o, inst_o, stall_cnt_o
   );

   modport master (
      output if_valid_i, pc_i, inst_i,
      output id_ready_i, flush_i,
      input  if_ready_o, id_valid_o,
      input  pc_o, inst_o, stall_cnt_o
   );
endinterface

// File: rtl/if_id_buf.sv
// Two-entry elastic IF/ID buffer with flush and stall counter.
// Ready to fetch depends on registered occupancy only.
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif

module if_id_buf (
   input logic   clk,
   input logic   rst_n,
   if_id_buf_if.slave bus
);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [31:0] pc_q [2];
   logic [31:0] pc_d [2];
   logic [31:0] inst_q [2];
   logic [31:0] inst_d [2];
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic if_ready;
   logic id_valid;
   logic push;
   logic pop;

   assign if_ready = (state_q != FULL);
   assign id_valid = (state_q != EMPTY);
   assign push = bus.if_valid_i & if_ready & ~bus.flush_i;
   assign pop  = id_valid & bus.id_ready_i & ~bus.flush_i;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      stall_cnt_d = stall_cnt_q;

      if (push) begin
         pc_d[wr_ptr_q]   = bus.pc_i;
         inst_d[wr_ptr_q] = bus.inst_i;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop)
         rd_ptr_d = ~rd_ptr_q;

      unique case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push & ~pop) state_d = FULL;
            else if (pop & ~push) state_d = EMPTY;
         end
         FULL: if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase

      // Flush overrides everything; slot contents stay but are unreachable.
      if (bus.flush_i) begin
         state_d  = EMPTY;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end

      if (id_valid & ~bus.id_ready_i & ~bus.flush_i)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         pc_q[0]     <= `CPU_RESET_ADDR;
         pc_q[1]     <= `CPU_RESET_ADDR;
         inst_q[0]   <= NOP_INST;
         inst_q[1]   <= NOP_INST;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pc_q[0]     <= pc_d[0];
         pc_q[1]     <= pc_d[1];
         inst_q[0]   <= inst_d[0];
         inst_q[1]   <= inst_d[1];
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.if_ready_o  = if_ready;
   assign bus.id_valid_o  = id_valid;
   assign bus.pc_o        = pc_q[rd_ptr_q];
   assign bus.inst_o      = id_valid ? inst_q[rd_ptr_q] : NOP_INST;
   assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_if_id_buf.sv
// Directed-vector bench for the IF/ID elastic buffer.
// Inputs change #1 after the rising edge; outputs are read there too.
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif

module tb_if_id_buf;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RST_PC = `CPU_RESET_ADDR;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   if_id_buf_if bus ();

   if_id_buf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic rdy,
                        input logic fl);
      bus.if_valid_i = v;
      bus.pc_i       = pc;
      bus.inst_i     = inst;
      bus.id_ready_i = rdy;
      bus.flush_i    = fl;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%0h exp=0", bus.id_valid_o);
      end
      checks++;
      if (bus.if_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%0h exp=1", bus.if_ready_o);
      end
      checks++;
      if (bus.inst_o !== NOP) begin
         failures++;
         $display("FAIL reset_inst got=%h exp=%h", bus.inst_o, NOP);
      end
      checks++;
      if (bus.pc_o !== RST_PC) begin
         failures++;
         $display("FAIL reset_pc got=%h exp=%h", bus.pc_o, RST_PC);
      end
      checks++;
      if (bus.stall_cnt_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_stall got=%h exp=0", bus.stall_cnt_o);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
         checks++;
         if (bus.if_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL stream_ready i=%0d got=%0h exp=1", i, bus.if_ready_o);
         end
         step();
         checks++;
         if (bus.id_valid_o !== 1'b1 || bus.pc_o !== 32'(4 * i) ||
             bus.inst_o !== 32'hA0 + 32'(i)) begin
            failures++;
            $display("FAIL stream_out i=%0d got=%0h/%h/%h exp=1/%h/%h",
                     i, bus.id_valid_o, bus.pc_o, bus.inst_o,
                     32'(4 * i), 32'hA0 + 32'(i));
         end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0 || bus.inst_o !== NOP) begin
         failures++;
         $display("FAIL stream_drain got=%0h/%h exp=0/%h",
                  bus.id_valid_o, bus.inst_o, NOP);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'h0, 32'hB0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h4, 32'hB1, 1'b0, 1'b0);
      step();
      checks++;
      if (bus.if_ready_o !== 1'b0 || bus.id_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_full got=rdy%0h/vld%0h exp=rdy0/vld1",
                  bus.if_ready_o, bus.id_valid_o);
      end
      drive(1'b1, 32'h8, 32'hB2, 1'b0, 1'b0);
      step();
      step();
      checks++;
      if (bus.pc_o !== 32'h0 || bus.inst_o !== 32'hB0 || bus.if_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL bp_hold got=%h/%h/rdy%0h exp=0/b0/rdy0",
                  bus.pc_o, bus.inst_o, bus.if_ready_o);
      end
      checks++;
      if (bus.stall_cnt_o !== 32'd3) begin
         failures++;
         $display("FAIL bp_stall got=%0d exp=3", bus.stall_cnt_o);
      end
      bus.id_ready_i = 1'b1;
      step();
      checks++;
      if (bus.pc_o !== 32'h4 || bus.inst_o !== 32'hB1 || bus.if_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_rel1 got=%h/%h/rdy%0h exp=4/b1/rdy1",
                  bus.pc_o, bus.inst_o, bus.if_ready_o);
      end
      step();
      checks++;
      if (bus.pc_o !== 32'h8 || bus.inst_o !== 32'hB2 || bus.id_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bp_rel2 got=%h/%h/vld%0h exp=8/b2/vld1",
                  bus.pc_o, bus.inst_o, bus.id_valid_o);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd3) begin
         failures++;
         $display("FAIL bp_drain got=vld%0h/cnt%0d exp=vld0/cnt3",
                  bus.id_valid_o, bus.stall_cnt_o);
      end
   endtask

   task automatic test_push_pop_one();
      drive(1'b1, 32'hC, 32'hC0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h10, 32'hC1, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.pc_o !== 32'h10 || bus.inst_o !== 32'hC1 ||
          bus.if_ready_o !== 1'b1 || bus.id_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL pp_one got=%h/%h/rdy%0h/vld%0h exp=10/c1/rdy1/vld1",
                  bus.pc_o, bus.inst_o, bus.if_ready_o, bus.id_valid_o);
      end
      drive(1'b1, 32'h14, 32'hC2, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.pc_o !== 32'h14 || bus.inst_o !== 32'hC2 || bus.if_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL pp_two got=%h/%h/rdy%0h exp=14/c2/rdy1",
                  bus.pc_o, bus.inst_o, bus.if_ready_o);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL pp_drain got=%0h exp=0", bus.id_valid_o);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h40, 32'hD0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h44, 32'hD1, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h20, 32'hDF, 1'b0, 1'b1);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0 || bus.inst_o !== NOP || bus.if_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL flush_empty got=vld%0h/%h/rdy%0h exp=vld0/%h/rdy1",
                  bus.id_valid_o, bus.inst_o, bus.if_ready_o, NOP);
      end
      checks++;
      if (bus.stall_cnt_o !== 32'd4) begin
         failures++;
         $display("FAIL flush_stall got=%0d exp=4", bus.stall_cnt_o);
      end
      drive(1'b1, 32'h100, 32'hE0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b1 || bus.pc_o !== 32'h100 || bus.inst_o !== 32'hE0) begin
         failures++;
         $display("FAIL flush_next got=vld%0h/%h/%h exp=vld1/100/e0",
                  bus.id_valid_o, bus.pc_o, bus.inst_o);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      checks++;
      if (bus.id_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_drain got=%0h exp=0", bus.id_valid_o);
      end
   endtask

   task automatic test_counter_wrap();
      drive(1'b1, 32'h200, 32'hF0, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      step();
      checks++;
      if (bus.stall_cnt_o !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL wrap_max got=%h exp=ffffffff", bus.stall_cnt_o);
      end
      step();
      checks++;
      if (bus.stall_cnt_o !== 32'd0) begin
         failures++;
         $display("FAIL wrap_zero got=%h exp=0", bus.stall_cnt_o);
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.stall_cnt_o !== 32'd0 || bus.id_valid_o !== 1'b0 ||
          bus.inst_o !== NOP || bus.pc_o !== RST_PC) begin
         failures++;
         $display("FAIL async_rst got=cnt%h/vld%0h/%h/%h exp=cnt0/vld0/%h/%h",
                  bus.stall_cnt_o, bus.id_valid_o, bus.inst_o, bus.pc_o, NOP, RST_PC);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_push_pop_one();
      test_flush();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
